// File: rtl/rx_rs232.sv
// rtl/rx_rs232.sv - 11-bit frame UART receiver (start, 8 data LSB first, guard, stop).
// Optional `RX_MAJORITY_VOTE_EN: 2-of-3 vote over the last three synchronized samples.
module rx_rs232 #(
    parameter int CLKS_PER_BIT = 104,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_s,
    input  logic       rst_s,
    input  logic       iDATA,
    output logic [7:0] oDATA,
    output logic       oVALID,
    output logic       oFERR,
    output logic       oBUSY
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, GUARD, STOP, WAIT_HIGH} state_t;

    state_t        state;
    logic          sync_d, sync_q;
    logic [CW-1:0] cnt;
    logic [3:0]    bitidx;
    logic [7:0]    shreg;
    logic          guard_bit;
    logic          sample;

    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            sync_d <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            sync_d <= iDATA;
            sync_q <= sync_d;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    // window holds sync_q at cnt-2, cnt-1 and cnt of the current sample point
    logic [1:0] hist_q;
    logic [2:0] window;

    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) hist_q <= 2'b11;
        else       hist_q <= {hist_q[0], sync_q};
    end

    assign window = {hist_q, sync_q};
    assign sample = (window[2] & window[1]) | (window[2] & window[0]) | (window[1] & window[0]);
`else
    assign sample = sync_q;
`endif

    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            state     <= IDLE;
            cnt       <= '0;
            bitidx    <= '0;
            shreg     <= '0;
            guard_bit <= 1'b0;
            oDATA     <= 8'h00;
            oVALID    <= 1'b0;
            oFERR     <= 1'b0;
            oBUSY     <= 1'b0;
        end else begin
            oVALID <= 1'b0;
            oFERR  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    oBUSY <= 1'b0;
                    if (!sync_q) begin
                        state <= START;
                        oBUSY <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt    <= '0;
                        bitidx <= '0;
                        if (!sample) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            oBUSY <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        shreg  <= {sample, shreg[7:1]};
                        bitidx <= bitidx + 1'b1;
                        if (bitidx == 4'd7) state <= GUARD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        guard_bit <= sample;
                        bitidx    <= bitidx + 1'b1;
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        // leaving at mid-stop lets a start bit right after the stop bit be caught
                        if (guard_bit && sample) begin
                            oDATA  <= shreg;
                            oVALID <= 1'b1;
                            oBUSY  <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            oFERR <= 1'b1;
                            state <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (sync_q) begin
                        state <= IDLE;
                        oBUSY <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    oBUSY <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/rx_rs232.md
Name: rx_rs232

Overview:
- Serial receiver matching the team's 11-bit UART transmitter framing.
- Frame: start (0), 8 data bits LSB first, bit 9 (guard/parity slot, transmitter drives 1), bit 10 (stop, 1).
- Sits between the board RX pin and the pattern-matching input logic.
- Delivers one byte per frame with a single-cycle valid strobe; flags framing errors.

Parameters:
- CLKS_PER_BIT, 104, clk_s cycles per serial bit; must be ≥ 8, even.
- HALF_BIT, CLKS_PER_BIT/2, offset from start-bit edge to mid-bit sample point.

Ports:
- clk_s  in  1  system clock
- rst_s  in  1  asynchronous, active-high reset
- iDATA  in  1  serial line, idle high, asynchronous to clk_s
- oDATA  out  8  last correctly received byte
- oVALID  out  1  one-cycle pulse: oDATA updated with a good frame
- oFERR  out  1  one-cycle pulse: frame received with bit 9 or bit 10 low
- oBUSY  out  1  high from start detection until return to IDLE

Behaviour:
Interface:
- One clock: clk_s.
- Reset rst_s is asynchronous and active-high.
- All outputs are registered.

Reset values:
- oDATA = 8'h00; oVALID = 0; oFERR = 0; oBUSY = 0.
- State IDLE, counters 0, shift register 0.
- Both synchronizer flops = 1.

Input conditioning:
- iDATA passes through a 2-flop synchronizer (sync_q) before any use; 2-cycle latency.

Counters:
- cnt: bit-time counter, 0..CLKS_PER_BIT-1.
- bitidx: 0..9, counts 8 data bits, bit 9 and bit 10.

States:
- IDLE:
  - oBUSY = 0.
  - sync_q == 0 → START, cnt = 0, oBUSY = 1.
- START:
  - cnt increments each cycle.
  - At cnt == HALF_BIT-1, sample sync_q:
    - 0 → DATA, cnt = 0, bitidx = 0.
    - 1 (glitch/false start) → IDLE, no pulse.
- DATA:
  - At cnt == CLKS_PER_BIT-1, sample into shift register, LSB first; cnt = 0, bitidx++.
  - After the 8th sample → GUARD.
- GUARD:
  - At cnt == CLKS_PER_BIT-1, record bit 9 sample; cnt = 0 → STOP.
- STOP:
  - At cnt == CLKS_PER_BIT-1, sample bit 10.
  - Bit 9 and bit 10 both 1:
    - oDATA <= shift register, oVALID = 1 for one cycle.
    - → IDLE.
  - Otherwise:
    - oFERR = 1 for one cycle, oDATA unchanged.
    - → WAIT_HIGH.
- WAIT_HIGH:
  - Stay until sync_q == 1, then → IDLE.
  - Prevents a break condition from re-triggering as back-to-back frames.
  - oBUSY = 1 while in this state.

Timing:
- Latency: oVALID is high in the cycle after clk_s edge k + 2 + HALF_BIT + 10·CLKS_PER_BIT, where k is the edge at which iDATA is first sampled low.
- For defaults this is k+1094.
- Back-to-back frames: IDLE is re-entered at mid-stop bit. A start bit immediately after the stop bit is detected with no lost frames.
- oVALID and oFERR are mutually exclusive and never asserted in consecutive cycles for the same frame.

Boundary conditions:
- Reset mid-frame: immediate return to reset values. No pulse is emitted for the partial frame.
- Line stuck low: one oFERR, then WAIT_HIGH indefinitely. No further pulses until the line rises and a new falling edge occurs.

Optional Feature:
RX_MAJORITY_VOTE_EN:
- Defined:
  - Every sample point (start check, data, bit 9, bit 10) uses a 2-of-3 majority of sync_q at cnt-2, cnt-1 and cnt.
  - A 3-bit sample history is added.
  - Sample timing and latency are unchanged.
- Undefined:
  - Single sample of sync_q at the sample point.
  - No history register.

Test Plan:
- Send 8'hA5 with good framing at 104 clk/bit → oVALID pulse exactly 1094 cycles after first low sample; oDATA = 8'hA5; oFERR stays 0.
- Two back-to-back frames 8'h00 then 8'hFF with no idle gap → two oVALID pulses 1144 cycles apart (11·104); oDATA = 8'h00 then 8'hFF.
- Low glitch of 20 cycles on idle line → returns to IDLE at START sample; no oVALID/oFERR; oBUSY high for ≤ 54 cycles.
- Frame 8'h3C with bit 10 driven 0 → oFERR pulse at cycle 1094; oDATA keeps previous value; line then held low 2000 cycles → no further pulses; release high, send 8'h5A → oVALID, oDATA = 8'h5A.
- Assert rst_s at bit 4 of frame 8'h81 → all outputs 0 immediately; release; next full frame 8'h42 → oVALID, oDATA = 8'h42.
- With RX_MAJORITY_VOTE_EN: 1-cycle inverted spike at each data-bit sample point of frame 8'h96 → oDATA = 8'h96. Without the macro the same stimulus → oDATA = 8'h69 (all bits inverted).
